// File: rtl/fp_single_pkg.sv
// Shared constants and types for the single-precision multiplier.
// Field widths, FSM state encoding and small operand helpers.
package fp_single_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 255;
   localparam int SIG_W   = MAN_W + 1;
   localparam int PROD_W  = 2 * SIG_W;
   localparam int CNT_W   = 5;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      NORM,
      DONE
   } state_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp_t;

   // Denormals are flushed, so a zero exponent field means zero.
   function automatic logic is_zero(input fp_t x);
      return (x.exp == '0);
   endfunction

   function automatic logic [SIG_W-1:0] significand(input fp_t x);
      return {1'b1, x.man};
   endfunction

endpackage

// File: rtl/integer_multiply.sv
// Sequential 24x24 -> 48 shift-add multiplier, one multiplier bit per cycle.
// done is high during the cycle whose closing edge performs the last step.
module integer_multiply
   import fp_single_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SIG_W-1:0]  mcand,
   input  logic [SIG_W-1:0]  mplier,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SIG_W - 1);

   logic [SIG_W-1:0]  mcand_q;
   logic [PROD_W-1:0] acc_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              busy_q;
   logic [SIG_W:0]    sum;

   // Upper half accumulates; the multiplier drains out of the lower half.
   always_comb begin
      sum = {1'b0, acc_q[PROD_W-1:SIG_W]};
      if (acc_q[0]) begin
         sum = sum + {1'b0, mcand_q};
      end
   end

   assign done    = busy_q && (cnt_q == LAST);
   assign product = acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (start) begin
         mcand_q <= mcand;
         acc_q   <= {{SIG_W{1'b0}}, mplier};
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else if (busy_q) begin
         acc_q <= {sum, acc_q[SIG_W-1:1]};
         if (done) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/single_multiply.sv
// IEEE-754 single-precision multiply: truncating, flush-to-zero, no NaN.
// Top FSM sequences operand capture, the shift-add core and normalisation.
module single_multiply
   import fp_single_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   output logic [31:0] c
);

   localparam logic signed [9:0] BIAS_S = 10'(BIAS);
   localparam logic signed [9:0] EMAX_S = 10'(EXP_MAX);

   state_t            state_q;
   state_t            state_d;
   fp_t               a_f;
   fp_t               b_f;
   logic              accept;
   logic              mul_done;
   logic [PROD_W-1:0] prod;

   logic              sign_q;
   logic              zero_q;
   logic [EXP_W-1:0]  ea_q;
   logic [EXP_W-1:0]  eb_q;
   logic [31:0]       c_q;

   logic              adj;
   logic [MAN_W-1:0]  man_n;
   logic signed [9:0] e_sum;
   logic              flush;
   logic              ovf;
   logic [31:0]       c_d;
   logic              unused_lo;

   assign a_f       = fp_t'(a);
   assign b_f       = fp_t'(b);
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid && in_ready;
   assign c         = c_q;
   assign unused_lo = ^prod[MAN_W-1:0];

   integer_multiply u_imul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept),
      .mcand   (significand(a_f)),
      .mplier  (significand(b_f)),
      .done    (mul_done),
      .product (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sign_q <= 1'b0;
         zero_q <= 1'b0;
         ea_q   <= '0;
         eb_q   <= '0;
      end else if (accept) begin
         sign_q <= a_f.sign ^ b_f.sign;
         zero_q <= is_zero(a_f) || is_zero(b_f);
         ea_q   <= a_f.exp;
         eb_q   <= b_f.exp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_d = MULT;
         MULT: if (mul_done) state_d = NORM;
         NORM: state_d = DONE;
         DONE: state_d = IDLE;
      endcase
   end

   // Product of two [1,2) significands lies in [1,4): at most one shift.
   always_comb begin
      adj   = prod[PROD_W-1];
      man_n = adj ? prod[PROD_W-2 -: MAN_W] : prod[PROD_W-3 -: MAN_W];
      e_sum = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q})
            - BIAS_S + $signed({9'd0, adj});
      flush = zero_q || (e_sum <= 10'sd0);
      ovf   = !flush && (e_sum >= EMAX_S);
      c_d   = {sign_q, e_sum[EXP_W-1:0], man_n};
      unique case (1'b1)
         flush:   c_d = {sign_q, 31'b0};
         ovf:     c_d = {sign_q, 8'hFF, 23'b0};
         default: c_d = {sign_q, e_sum[EXP_W-1:0], man_n};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c_q <= '0;
      end else if (state_q == NORM) begin
         c_q <= c_d;
      end
   end

endmodule

// File: tb/tb_single_multiply.sv
// Self-checking bench for single_multiply: reference model + scoreboard.
// Directed vectors, handshake spacing, reset abort and random regression.
module tb_single_multiply;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic [31:0] c;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [31:0] res;
      int          due;
   } exp_t;

   exp_t q[$];
   int   dut_acc[$];

   always #5 clk = ~clk;

   single_multiply dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .c         (c)
   );

   function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                           input logic [31:0] y);
      logic        s;
      int          ex;
      int          ey;
      int          e;
      longint      p;
      logic [22:0] m;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      if (ex == 0 || ey == 0) return {s, 31'b0};
      p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      if ((p >> 47) != 0) begin
         m = 23'(p >> 24);
         e = ex + ey - 127 + 1;
      end else begin
         m = 23'(p >> 23);
         e = ex + ey - 127;
      end
      if (e <= 0) return {s, 31'b0};
      if (e >= 255) return {s, 8'hFF, 23'b0};
      return {s, 8'(e), m};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, want, cyc);
      end
   endtask

   // Model: one outstanding op, result due on the 26th cycle after accept.
   always @(posedge clk) begin
      bit rdy;
      rdy = (q.size() == 0);
      if (rst) begin
         q.delete();
      end else begin
         if (in_valid && rdy) q.push_back('{ref_mul(a, b), cyc + 26});
         if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      end
      cyc++;
   end

   always @(negedge clk) begin
      bit ev;
      if (chk_en) begin
         ev = (q.size() > 0) && (q[0].due == cyc);
         chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
         chk("out_valid", 32'(out_valid), 32'(ev));
         if (ev) chk("c", c, q[0].res);
         if (in_valid && in_ready && !rst) dut_acc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 60) begin
         tick();
         n++;
      end
      if (n >= 60) chk("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input string name, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] want);
      int k;
      wait_ready();
      a = x;
      b = y;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk({name, "_lat"}, 32'(k), 32'd26);
      chk(name, c, want);
      tick();
   endtask

   function automatic logic [31:0] rnd_normal();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)),
              23'($urandom)};
   endfunction

   initial begin
      chk("pin_2x3", ref_mul(32'h40000000, 32'h40400000), 32'h40C00000);
      chk("pin_1p5sq", ref_mul(32'h3FC00000, 32'h3FC00000), 32'h40100000);
      chk("pin_ovf", ref_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
      chk("pin_unf", ref_mul(32'h00800000, 32'h00800000), 32'h00000000);

      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_c", c, 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk_en = 1'b1;
      tick();

      run_op("mul_2x3", 32'h40000000, 32'h40400000, 32'h40C00000);
      run_op("mul_1p5sq", 32'h3FC00000, 32'h3FC00000, 32'h40100000);
      run_op("mul_neg", 32'hBF800000, 32'h40800000, 32'hC0800000);
      run_op("mul_zero", 32'h00000000, 32'h40490FDB, 32'h00000000);
      run_op("mul_ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000);
      run_op("mul_unf", 32'h00800000, 32'h00800000, 32'h00000000);
      run_op("mul_negzero", 32'h80000000, 32'h3F800000, 32'h80000000);

      // Abort at cycle 10 of MULT.
      wait_ready();
      a = 32'h40000000;
      b = 32'h40400000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (30) tick();
      run_op("after_abort", 32'h3FC00000, 32'h40000000, 32'h40400000);

      // Reset wins over a simultaneous accept.
      wait_ready();
      a = 32'h40000000;
      b = 32'h40000000;
      in_valid = 1'b1;
      rst = 1'b1;
      tick();
      in_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_prio_in_ready", 32'(in_ready), 32'd1);
      repeat (30) tick();

      // Held in_valid with operands changing every cycle.
      dut_acc.delete();
      wait_ready();
      in_valid = 1'b1;
      for (int i = 0; i < 5 * 27; i++) begin
         a = rnd_normal();
         b = rnd_normal();
         tick();
      end
      in_valid = 1'b0;
      repeat (30) tick();
      chk("hold_accepts", 32'(dut_acc.size()), 32'd5);
      for (int i = 1; i < dut_acc.size(); i++)
         chk("hold_spacing", 32'(dut_acc[i] - dut_acc[i-1]), 32'd27);

      // Random regression; the scoreboard checks every result.
      wait_ready();
      in_valid = 1'b1;
      for (int i = 0; i < 1000 * 27; i++) begin
         a = rnd_normal();
         b = rnd_normal();
         tick();
      end
      in_valid = 1'b0;
      repeat (30) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
